power_select_encoder: RTL and testbench
=======================================

POWER_SELECT_ENCODER -- requirements
Module: power_select_encoder

Interface
REQ-001 DEBOUNCE_CYCLES, 500000, consecutive stable cycles (10 ms at 50 MHz) required before a key level is accepted; legal range 2..2^20-1.
REQ-002 clk  input  1  system clock; single clock domain; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 key_sel_r_n  input  1  right player "next power" pushbutton, raw, active-low, asynchronous to clk.
REQ-005 key_lock_r_n  input  1  right player "lock" pushbutton, raw, active-low.
REQ-006 key_sel_l_n  input  1  left player "next power" pushbutton, raw, active-low.
REQ-007 key_lock_l_n  input  1  left player "lock" pushbutton, raw, active-low.
REQ-008 key_clear_n  input  1  round clear pushbutton, raw, active-low.
REQ-009 state  output  4  selection event code for the 7-segment power display decoder; registered.
REQ-010 sel_r, sel_l  output  2 each  current power per player: 0 none, 1 invisibility, 2 flexibility, 3 camouflage.
REQ-011 locked_r, locked_l  output  1 each  player selection locked.
REQ-012 both_locked  output  1  level; high when locked_r and locked_l are both high.

Function
REQ-013 Each of the five keys SHALL pass through a 2-flop synchronizer, then a debouncer that changes its accepted level on the DEBOUNCE_CYCLES-th consecutive cycle the synchronized level differs from it; any matching sample SHALL zero that key's counter.
REQ-014 A press event SHALL be a one-cycle registered pulse, issued the cycle after an accepted 1->0 transition; releases produce no event.
REQ-015 Latency: raw key held low from edge 0 SHALL change state/sel outputs at edge DEBOUNCE_CYCLES+4, no earlier or later.
REQ-016 Sel press, player unlocked: sel SHALL advance 0->1, 1->2, 2->3, 3->1 (never returns to 0 except by clear/reset).
REQ-017 Sel press, player locked: ignored; no output change.
REQ-018 Lock press: if sel != 0 and unlocked, locked SHALL set; if sel == 0 or already locked, ignored; lock is cleared only by clear/reset.
REQ-019 state encoding on a right sel update: 4'b0100 for 1, 4'b0101 for 2, 4'b0110 for 3; left: 4'b0111, 4'b1000, 4'b1001; clear: 4'b0000.
REQ-020 state SHALL hold its last value when no event occurs; codes outside REQ-019 SHALL never be driven.
REQ-021 Lock events SHALL not change state.
REQ-022 Clear press: sel_r, sel_l, locked_r, locked_l SHALL go to 0 and state to 4'b0000 in the same edge; clear is honoured regardless of lock status.
REQ-023 Simultaneous right and left sel events: right SHALL update at the normal edge; left event SHALL be held in a 1-deep pending flag and applied (sel_l and state) exactly one edge later.
REQ-024 A new left sel event arriving while pending is set SHALL be dropped; debounce guarantees at most one event per player per DEBOUNCE_CYCLES.
REQ-025 Clear simultaneous with any sel/lock event, or with pending set: clear wins; other events and pending SHALL be discarded.
REQ-026 Sel and lock events for the same player in the same cycle: sel applied first, then lock evaluated against the new sel.
REQ-027 both_locked SHALL be registered alongside the lock flags (same edge).

Reset
REQ-028 On rst_n low, asynchronously: state=4'b0000, sel_r=sel_l=0, locked_r=locked_l=both_locked=0, pending cleared, debouncer levels=1 (released), counters=0, synchronizer flops=1.
REQ-029 Keys held low across reset release SHALL be accepted as presses after full debounce (REQ-015 timing from the first clk edge after release).
REQ-030 rst_n asserted mid-debounce or mid-pending SHALL discard the in-flight event; no event after release unless key is still held.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Right sel pressed 3 times, each held 10 cycles -> state 0100, 0101, 0110 in turn; sel_r 1,2,3; first change at edge 8.
REQ-032 key_sel_l_n glitching low for 3 cycles, repeatedly -> no change; state stays 0000.
REQ-033 Right and left sel pressed on same edge from reset -> state 0100 at edge 8, 0111 at edge 9; sel_r=1, sel_l=1.
REQ-034 Lock right with sel_r=0 -> ignored; sel to 2, lock, sel again -> sel_r stays 2, locked_r=1, state stays 0101.
REQ-035 Both players locked (both_locked=1), then clear -> all outputs 0, state 0000 on the same edge.
REQ-036 rst_n pulsed low 2 cycles after right key press while debouncing -> outputs reset immediately; key released before rst_n high -> no event follows.

Source files
------------

// File: rtl/power_select_encoder.sv
// Power selection encoder for a two-player game.
// Five raw active-low pushbuttons are synchronized and debounced; accepted
// presses step each player's power, lock it in, or clear the round. The
// 4-bit state output feeds the 7-segment power display decoder.
module power_select_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_sel_r_n,
  input  logic       key_lock_r_n,
  input  logic       key_sel_l_n,
  input  logic       key_lock_l_n,
  input  logic       key_clear_n,
  output logic [3:0] state,
  output logic [1:0] sel_r,
  output logic [1:0] sel_l,
  output logic       locked_r,
  output logic       locked_l,
  output logic       both_locked
);

  localparam int unsigned CW      = 20;
  localparam int unsigned NKEYS   = 5;
  localparam int unsigned K_SEL_R  = 0;
  localparam int unsigned K_LOCK_R = 1;
  localparam int unsigned K_SEL_L  = 2;
  localparam int unsigned K_LOCK_L = 3;
  localparam int unsigned K_CLEAR  = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] raw_n;
  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] level;
  logic [NKEYS-1:0] level_d;
  logic [NKEYS-1:0] press;
  logic [CW-1:0]    cnt [NKEYS];

  logic       pending;
  logic [3:0] state_nx;
  logic [1:0] sel_r_nx;
  logic [1:0] sel_l_nx;
  logic       locked_r_nx;
  logic       locked_l_nx;
  logic       pending_nx;
  logic       both_nx;

  assign raw_n = {key_clear_n, key_lock_l_n, key_sel_l_n, key_lock_r_n, key_sel_r_n};

  // Power cycles 1 -> 2 -> 3 -> 1; 0 is only reachable by clear/reset.
  function automatic logic [1:0] next_power(input logic [1:0] v);
    return (v == 2'd3) ? 2'd1 : v + 2'd1;
  endfunction

  function automatic logic [3:0] code_right(input logic [1:0] v);
    return 4'd3 + {2'b00, v};
  endfunction

  function automatic logic [3:0] code_left(input logic [1:0] v);
    return 4'd6 + {2'b00, v};
  endfunction

  // Synchronize, debounce and edge-detect all five keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '1;
      sync2   <= '1;
      level   <= '1;
      level_d <= '1;
      press   <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw_n;
      sync2   <= sync1;
      level_d <= level;
      // one-cycle pulse the cycle after the accepted level falls
      press   <= level_d & ~level;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        if (sync2[i] != level[i]) begin
          if (cnt[i] == CNT_LAST) begin
            level[i] <= sync2[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Resolve this cycle's press events into next selection/lock/display values.
  always_comb begin
    state_nx    = state;
    sel_r_nx    = sel_r;
    sel_l_nx    = sel_l;
    locked_r_nx = locked_r;
    locked_l_nx = locked_l;
    pending_nx  = pending;
    if (press[K_CLEAR]) begin
      state_nx    = 4'b0000;
      sel_r_nx    = 2'd0;
      sel_l_nx    = 2'd0;
      locked_r_nx = 1'b0;
      locked_l_nx = 1'b0;
      pending_nx  = 1'b0;
    end else begin
      if (press[K_SEL_R] && !locked_r) begin
        sel_r_nx = next_power(sel_r);
        state_nx = code_right(sel_r_nx);
      end
      // lock judged against the selection as updated this same edge
      if (press[K_LOCK_R] && !locked_r && (sel_r_nx != 2'd0)) begin
        locked_r_nx = 1'b1;
      end
      // a left update deferred by a right collision takes the display now;
      // any fresh left sel arriving meanwhile is dropped
      if (pending) begin
        pending_nx = 1'b0;
        if (!locked_l) begin
          sel_l_nx = next_power(sel_l);
          state_nx = code_left(sel_l_nx);
        end
      end else if (press[K_SEL_L]) begin
        if (press[K_SEL_R]) begin
          pending_nx = 1'b1;
        end else if (!locked_l) begin
          sel_l_nx = next_power(sel_l);
          state_nx = code_left(sel_l_nx);
        end
      end
      if (press[K_LOCK_L] && !locked_l && (sel_l_nx != 2'd0)) begin
        locked_l_nx = 1'b1;
      end
    end
    both_nx = locked_r_nx & locked_l_nx;
  end

  // Register all player-visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= 4'b0000;
      sel_r       <= 2'd0;
      sel_l       <= 2'd0;
      locked_r    <= 1'b0;
      locked_l    <= 1'b0;
      both_locked <= 1'b0;
      pending     <= 1'b0;
    end else begin
      state       <= state_nx;
      sel_r       <= sel_r_nx;
      sel_l       <= sel_l_nx;
      locked_r    <= locked_r_nx;
      locked_l    <= locked_l_nx;
      both_locked <= both_nx;
      pending     <= pending_nx;
    end
  end

endmodule

// File: tb/tb_power_select_encoder.sv
// Self-checking bench for power_select_encoder with a short debounce window.
module tb_power_select_encoder;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] keys_n = '1;  // {clear, lock_l, sel_l, lock_r, sel_r}
  logic [3:0] state;
  logic [1:0] sel_r, sel_l;
  logic       locked_r, locked_l, both_locked;
  logic [10:0] dvec;

  int errors = 0;
  int checks = 0;

  // reference model: raw sample history, accepted levels, event delay line
  logic [4:0] hist [N+2];
  logic [4:0] acc, p1, p2;
  int m_state, m_sr, m_sl;
  bit m_lr, m_ll, m_pend;

  always #5 clk = ~clk;

  power_select_encoder #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_sel_r_n(keys_n[0]), .key_lock_r_n(keys_n[1]),
    .key_sel_l_n(keys_n[2]), .key_lock_l_n(keys_n[3]),
    .key_clear_n(keys_n[4]),
    .state(state), .sel_r(sel_r), .sel_l(sel_l),
    .locked_r(locked_r), .locked_l(locked_l), .both_locked(both_locked)
  );

  assign dvec = {state, sel_r, sel_l, locked_r, locked_l, both_locked};

  function automatic logic [10:0] mvec();
    return {4'(m_state), 2'(m_sr), 2'(m_sl), m_lr, m_ll, m_lr & m_ll};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N + 2; i++) hist[i] = '1;
    acc = '1; p1 = '0; p2 = '0;
    m_state = 0; m_sr = 0; m_sl = 0; m_lr = 0; m_ll = 0; m_pend = 0;
  endtask

  // one rising edge of the model: apply presses accepted two edges ago,
  // then accept a new level once the last N synchronized samples disagree
  task automatic model_step();
    logic [4:0] ev, fresh;
    bit differs;
    ev = p2;
    if (ev[4]) begin
      m_state = 0; m_sr = 0; m_sl = 0; m_lr = 0; m_ll = 0; m_pend = 0;
    end else begin
      if (ev[0] && !m_lr) begin m_sr = (m_sr % 3) + 1; m_state = 3 + m_sr; end
      if (ev[1] && !m_lr && m_sr != 0) m_lr = 1;
      if (m_pend) begin
        m_pend = 0;
        if (!m_ll) begin m_sl = (m_sl % 3) + 1; m_state = 6 + m_sl; end
      end else if (ev[2]) begin
        if (ev[0]) m_pend = 1;
        else if (!m_ll) begin m_sl = (m_sl % 3) + 1; m_state = 6 + m_sl; end
      end
      if (ev[3] && !m_ll && m_sl != 0) m_ll = 1;
    end
    p2 = p1;
    for (int i = N + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = keys_n;
    fresh = '0;
    for (int k = 0; k < 5; k++) begin
      differs = 1;
      for (int i = 2; i <= N + 1; i++) if (hist[i][k] == acc[k]) differs = 0;
      if (differs) begin
        acc[k] = ~acc[k];
        if (!acc[k]) fresh[k] = 1'b1;
      end
    end
    p1 = fresh;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic press_key(input int k);
    keys_n[k] = 1'b0;
    repeat (8) tick();
    keys_n[k] = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    keys_n = '1;
    rst_n = 1'b0;
    model_reset();
    tick();
    checks++;
    if (dvec !== 11'b0) begin errors++; $display("FAIL reset_vals: got %b expected %b", dvec, 11'b0); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (dvec !== 11'b0) begin errors++; $display("FAIL reset_idle: got %b expected %b", dvec, 11'b0); end
  endtask

  task automatic test_sel_sequence();
    keys_n = '1;
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      keys_n[0] = 1'b0;
      for (int j = 1; j <= 10; j++) begin
        tick();
        if (j == 7) begin
          checks++;
          if (state !== 4'((p == 0) ? 0 : 3 + p) || sel_r !== 2'(p)) begin
            errors++; $display("FAIL early_edge p%0d: got state=%b sel_r=%0d expected unchanged", p, state, sel_r);
          end
        end
        if (j == 8) begin
          checks++;
          if (state !== 4'(4 + p) || sel_r !== 2'(p + 1)) begin
            errors++; $display("FAIL latency_edge p%0d: got state=%b sel_r=%0d expected state=%b sel_r=%0d",
                                p, state, sel_r, 4'(4 + p), p + 1);
          end
        end
      end
      keys_n[0] = 1'b1;
      repeat (10) tick();
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL sel_seq_model p%0d: got %b expected %b", p, dvec, mvec()); end
    end
  endtask

  task automatic test_glitch();
    keys_n = '1;
    apply_reset();
    repeat (6) begin
      keys_n[2] = 1'b0;
      repeat (3) tick();
      keys_n[2] = 1'b1;
      repeat (3) tick();
      checks++;
      if (state !== 4'b0000 || sel_l !== 2'd0) begin
        errors++; $display("FAIL glitch: got state=%b sel_l=%0d expected 0000/0", state, sel_l);
      end
    end
  endtask

  task automatic test_simultaneous();
    keys_n = '1;
    apply_reset();
    keys_n[0] = 1'b0;
    keys_n[2] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 8) begin
        checks++;
        if (state !== 4'b0100 || sel_r !== 2'd1 || sel_l !== 2'd0) begin
          errors++; $display("FAIL simul_right: got state=%b sel_r=%0d sel_l=%0d expected 0100/1/0", state, sel_r, sel_l);
        end
      end
      if (j == 9) begin
        checks++;
        if (state !== 4'b0111 || sel_r !== 2'd1 || sel_l !== 2'd1) begin
          errors++; $display("FAIL simul_left: got state=%b sel_r=%0d sel_l=%0d expected 0111/1/1", state, sel_r, sel_l);
        end
      end
    end
    keys_n = '1;
    repeat (10) tick();
    checks++;
    if (dvec !== mvec()) begin errors++; $display("FAIL simul_model: got %b expected %b", dvec, mvec()); end
  endtask

  task automatic test_lock();
    keys_n = '1;
    apply_reset();
    press_key(1);
    checks++;
    if (locked_r !== 1'b0) begin errors++; $display("FAIL lock_sel0: got locked_r=%b expected 0", locked_r); end
    press_key(0);
    press_key(0);
    press_key(1);
    press_key(0);
    checks++;
    if (sel_r !== 2'd2 || locked_r !== 1'b1 || state !== 4'b0101) begin
      errors++; $display("FAIL lock_hold: got sel_r=%0d locked_r=%b state=%b expected 2/1/0101", sel_r, locked_r, state);
    end
  endtask

  task automatic test_clear_both();
    keys_n = '1;
    apply_reset();
    press_key(0);
    press_key(2);
    press_key(1);
    press_key(3);
    checks++;
    if (both_locked !== 1'b1 || locked_l !== 1'b1) begin
      errors++; $display("FAIL both_locked: got both=%b locked_l=%b expected 1/1", both_locked, locked_l);
    end
    keys_n[4] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 7) begin
        checks++;
        if (dvec !== 11'b0111_01_01_111) begin errors++; $display("FAIL clear_early: got %b expected %b", dvec, 11'b0111_01_01_111); end
      end
      if (j == 8) begin
        checks++;
        if (dvec !== 11'b0) begin errors++; $display("FAIL clear_edge: got %b expected %b", dvec, 11'b0); end
      end
    end
    keys_n = '1;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    bit seen_change;
    keys_n = '1;
    apply_reset();
    press_key(2);
    keys_n[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dvec !== 11'b0) begin errors++; $display("FAIL async_reset: got %b expected %b", dvec, 11'b0); end
    tick();
    keys_n[0] = 1'b1;
    tick();
    rst_n = 1'b1;
    seen_change = 0;
    repeat (20) begin
      tick();
      if (dvec !== 11'b0) seen_change = 1;
    end
    checks++;
    if (seen_change) begin errors++; $display("FAIL reset_discard: got %b expected %b", dvec, 11'b0); end
  endtask

  task automatic test_random();
    int hold [5];
    keys_n = '1;
    apply_reset();
    for (int k = 0; k < 5; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 5; k++) begin
        if (hold[k] == 0) begin
          if (k == 4) keys_n[k] = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
          else keys_n[k] = $urandom_range(0, 1) ? 1'b0 : 1'b1;
          hold[k] = $urandom_range(1, 14);
        end else begin
          hold[k]--;
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
      checks++;
      if (dvec !== mvec()) begin
        errors++; $display("FAIL random c%0d: got %b expected %b", c, dvec, mvec());
      end
    end
    keys_n = '1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sel_sequence();
    test_glitch();
    test_simultaneous();
    test_lock();
    test_clear_both();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
